// File: rtl/correlator_sequencer.sv
// Slot/sample/block sequencer feeding the correlate and accumulate stages (vis_clock domain).
// Define SEQ_STATS_EN to add the frames_o / skips_o statistics counters.
module correlator_sequencer #(
  parameter int                TRATE  = 15,
  parameter int                COUNT  = 15,
  parameter int                BLOCKS = 4,
  parameter logic [TRATE-1:0]  AUTOS  = {TRATE{1'b0}},
  parameter int                TBITS  = (TRATE > 1) ? $clog2(TRATE) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             acc_ready_i,
  input  logic             valid_i,
  input  logic             first_i,
  output logic             valid_o,
  output logic [TBITS-1:0] taddr_o,
  output logic             first_o,
  output logic             last_o,
  output logic             auto_o,
  output logic             acc_first_o,
  output logic             acc_last_o,
  output logic             vis_start_o,
  output logic             vis_frame_o,
  output logic             sync_err_o
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]      frames_o,
  output logic [15:0]      skips_o
`endif
);

  localparam int SBITS = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int BBITS = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r;
  logic [TBITS-1:0] tcnt_r;
  logic [SBITS-1:0] scnt_r;
  logic [BBITS-1:0] bcnt_r;

  logic             start_s, origin_s, emit_s, resync_s, restart_s;
  logic [TBITS-1:0] cur_t_s;
  logic [SBITS-1:0] cur_s_s;
  logic [BBITS-1:0] cur_b_s;
  logic             t_wrap_s, s_wrap_s, b_wrap_s, frame_end_s;

  // Decide whether this cycle emits a slot and which counter position it represents.
  always_comb begin
    start_s  = enable_i & acc_ready_i & valid_i & first_i;
    origin_s = (tcnt_r == TBITS'(0)) && (scnt_r == SBITS'(0));
    if (state_r == RUN) begin
      emit_s   = valid_i;
      resync_s = valid_i & first_i & ~origin_s;
    end else begin
      emit_s   = start_s;
      resync_s = 1'b0;
    end
    // A frame start or a resync both restart the stream from the origin.
    restart_s = emit_s & ((state_r == IDLE) | resync_s);
    if (restart_s) begin
      cur_t_s = TBITS'(0);
      cur_s_s = SBITS'(0);
      cur_b_s = BBITS'(0);
    end else begin
      cur_t_s = tcnt_r;
      cur_s_s = scnt_r;
      cur_b_s = bcnt_r;
    end
    t_wrap_s    = (cur_t_s == TBITS'(TRATE - 1));
    s_wrap_s    = (cur_s_s == SBITS'(COUNT - 1));
    b_wrap_s    = (cur_b_s == BBITS'(BLOCKS - 1));
    frame_end_s = t_wrap_s & s_wrap_s & b_wrap_s;
  end

  // Sequencer state, position counters and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tcnt_r      <= TBITS'(0);
      scnt_r      <= SBITS'(0);
      bcnt_r      <= BBITS'(0);
      valid_o     <= 1'b0;
      taddr_o     <= TBITS'(0);
      first_o     <= 1'b0;
      last_o      <= 1'b0;
      auto_o      <= 1'b0;
      acc_first_o <= 1'b0;
      acc_last_o  <= 1'b0;
      vis_start_o <= 1'b0;
      vis_frame_o <= 1'b0;
      sync_err_o  <= 1'b0;
    end else begin
      if (emit_s) begin
        tcnt_r <= t_wrap_s ? TBITS'(0) : cur_t_s + TBITS'(1);
        if (t_wrap_s) begin
          scnt_r <= s_wrap_s ? SBITS'(0) : cur_s_s + SBITS'(1);
        end else begin
          scnt_r <= cur_s_s;
        end
        if (t_wrap_s & s_wrap_s) begin
          bcnt_r <= b_wrap_s ? BBITS'(0) : cur_b_s + BBITS'(1);
        end else begin
          bcnt_r <= cur_b_s;
        end
        // Returning to IDLE at frame end lets the next frame start seamlessly or stall.
        state_r <= frame_end_s ? IDLE : RUN;
      end else begin
        state_r <= state_r;
      end
      valid_o     <= emit_s;
      taddr_o     <= emit_s ? cur_t_s : TBITS'(0);
      first_o     <= emit_s & (cur_s_s == SBITS'(0));
      last_o      <= emit_s & s_wrap_s;
      auto_o      <= emit_s & AUTOS[cur_t_s];
      acc_first_o <= emit_s & s_wrap_s & (cur_b_s == BBITS'(0));
      acc_last_o  <= emit_s & s_wrap_s & b_wrap_s;
      vis_start_o <= restart_s;
      vis_frame_o <= emit_s | (state_r == RUN);
      if (resync_s) begin
        sync_err_o <= 1'b1;
      end else begin
        sync_err_o <= sync_err_o;
      end
    end
  end

`ifdef SEQ_STATS_EN
  // Completed-frame and stalled-start statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frames_o <= 16'd0;
      skips_o  <= 16'd0;
    end else begin
      if (acc_last_o && (taddr_o == TBITS'(TRATE - 1))) begin
        frames_o <= frames_o + 16'd1;
      end else begin
        frames_o <= frames_o;
      end
      if ((state_r == IDLE) && enable_i && first_i && valid_i && !acc_ready_i) begin
        skips_o <= skips_o + 16'd1;
      end else begin
        skips_o <= skips_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_correlator_sequencer.sv
// Directed self-checking bench for correlator_sequencer (TRATE=15, COUNT=15, BLOCKS=4, AUTOS=15'h0001).
module tb_correlator_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, enable_i, acc_ready_i, valid_i, first_i;
  logic        valid_o, first_o, last_o, auto_o, acc_first_o, acc_last_o;
  logic        vis_start_o, vis_frame_o, sync_err_o;
  logic [3:0]  taddr_o;
`ifdef SEQ_STATS_EN
  logic [15:0] frames_o, skips_o;
`endif
  logic [12:0] obs;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  correlator_sequencer #(
    .TRATE(15), .COUNT(15), .BLOCKS(4), .AUTOS(15'h0001)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .acc_ready_i(acc_ready_i),
    .valid_i(valid_i), .first_i(first_i), .valid_o(valid_o), .taddr_o(taddr_o),
    .first_o(first_o), .last_o(last_o), .auto_o(auto_o), .acc_first_o(acc_first_o),
    .acc_last_o(acc_last_o), .vis_start_o(vis_start_o), .vis_frame_o(vis_frame_o),
    .sync_err_o(sync_err_o)
`ifdef SEQ_STATS_EN
    , .frames_o(frames_o), .skips_o(skips_o)
`endif
  );

  assign obs = {valid_o, taddr_o, first_o, last_o, auto_o, acc_first_o, acc_last_o,
                vis_start_o, vis_frame_o, sync_err_o};

  // Expected output vector for a slot at (t, s, b); status bits only when not valid.
  function automatic logic [12:0] expv(input logic v, input int t, input int s, input int b,
                                       input logic st, input logic fr, input logic se);
    logic [3:0] ta;
    logic       fi, la;
    ta = 4'(t);
    fi = (s == 0);
    la = (s == 14);
    if (v) return {1'b1, ta, fi, la, (t == 0), la & (b == 0), la & (b == 3), st, fr, se};
    else   return {1'b0, 4'd0, 6'd0, fr, se};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable_i = 1'b0; acc_ready_i = 1'b0; valid_i = 1'b0; first_i = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset got %h exp %h", obs, 13'd0); end
`ifdef SEQ_STATS_EN
    checks++;
    if ({frames_o, skips_o} !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %h exp 0", {frames_o, skips_o});
    end
`endif
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_frames();
    logic [12:0] e;
    enable_i = 1'b1; acc_ready_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 1801; k++) begin
      first_i = (k % 225 == 0) && (k < 1800);
      step();
      if (k < 1800) e = expv(1'b1, k % 15, (k % 225) / 15, (k / 225) % 4, k % 900 == 0, 1'b1, 1'b0);
      else          e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL frames k=%0d got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_gap();
    logic [12:0] e;
    int n;
    for (int c = 0; c < 904; c++) begin
      n = (c < 100) ? c : c - 3;
      if (c >= 100 && c < 103) begin
        valid_i = 1'b0; first_i = 1'b0;
        e = expv(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      end else begin
        valid_i = 1'b1; first_i = (n % 225 == 0) && (n < 900);
        if (n < 900) e = expv(1'b1, n % 15, (n % 225) / 15, (n / 225) % 4, n == 0, 1'b1, 1'b0);
        else         e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      end
      step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL gap c=%0d got %h exp %h", c, obs, e); end
    end
  endtask

  task automatic test_enable_drop();
    logic [12:0] e;
    valid_i = 1'b1;
    for (int n = 0; n < 901; n++) begin
      enable_i = (n < 100);
      first_i  = (n % 225 == 0);
      step();
      if (n < 900) e = expv(1'b1, n % 15, (n % 225) / 15, (n / 225) % 4, n == 0, 1'b1, 1'b0);
      else         e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL enable_drop n=%0d got %h exp %h", n, obs, e); end
    end
    enable_i = 1'b1; first_i = 1'b0;
  endtask

  task automatic test_not_ready();
    logic [12:0] e;
    valid_i = 1'b1; enable_i = 1'b1; acc_ready_i = 1'b0;
    for (int c = 0; c < 15; c++) begin
      first_i = (c == 0);
      step();
      e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL not_ready_idle c=%0d got %h exp %h", c, obs, e); end
    end
    for (int n = 0; n < 901; n++) begin
      acc_ready_i = (n < 50);
      first_i     = (n % 225 == 0) && (n < 900);
      step();
      if (n < 900) e = expv(1'b1, n % 15, (n % 225) / 15, (n / 225) % 4, n == 0, 1'b1, 1'b0);
      else         e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL not_ready n=%0d got %h exp %h", n, obs, e); end
    end
`ifdef SEQ_STATS_EN
    checks++;
    if (skips_o !== 16'd1) begin errors++; $display("FAIL skips got %0d exp 1", skips_o); end
    checks++;
    if (frames_o !== 16'd5) begin errors++; $display("FAIL frames_cnt got %0d exp 5", frames_o); end
`endif
    acc_ready_i = 1'b1;
  endtask

  task automatic test_resync();
    logic [12:0] e;
    int n;
    valid_i = 1'b1; enable_i = 1'b1; acc_ready_i = 1'b1;
    for (int c = 0; c < 953; c++) begin
      n = (c < 52) ? c : c - 52;
      first_i = (n % 225 == 0) && (n < 900);
      step();
      if (n < 900) e = expv(1'b1, n % 15, (n % 225) / 15, (n / 225) % 4, n == 0, 1'b1, c >= 52);
      else         e = expv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL resync c=%0d got %h exp %h", c, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    valid_i = 1'b1; enable_i = 1'b1; acc_ready_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      first_i = (n == 0);
      step();
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL async_reset got %h exp %h", obs, 13'd0); end
`ifdef SEQ_STATS_EN
    checks++;
    if ({frames_o, skips_o} !== 32'd0) begin
      errors++; $display("FAIL async_reset_stats got %h exp 0", {frames_o, skips_o});
    end
`endif
    first_i = 1'b0;
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 45; n++) begin
      first_i = (n == 0);
      step();
      e = expv(1'b1, n % 15, n / 15, 0, n == 0, 1'b1, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL post_reset n=%0d got %h exp %h", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_gap();
    test_enable_drop();
    test_not_ready();
    test_resync();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
